ycr_clk_gate_mc: RTL and testbench
==================================

Name: ycr_clk_gate_mc

Overview:
Parametrised multi-channel core clock-gate controller. Gates the core clock once the core signals idle, after an optional programmable sleep delay. Ungates on any enabled interrupt from NIRQ channels after a programmable wake hold-off. Records which sources caused the wake in a sticky status vector. Sits between the clock tree and a RISC-V core; runs on the ungated clock and drives a ctech_clk_gate cell.

Parameters:
NIRQ, 4, number of wake interrupt channels (1..16)
CNT_W, 4, width of sleep-delay and wake-hold counters/configs

Ports:
clk_in  input  1  ungated source clock; all logic on posedge
reset  input  1  synchronous, active-high reset
cfg_mode  input  2  00 no gating, 01 IRQ-wake gating, 10 force gate, 11 treated as 00; 2-flop synced internally
cfg_irq_mask  input  NIRQ  per-channel wake enable; quasi-static
cfg_sleep_dly  input  CNT_W  cycles between idle detect and gating; quasi-static
cfg_wake_cnt  input  CNT_W  wake hold-off length control; quasi-static
dst_idle  input  1  core idle request, asynchronous; 2-flop synced internally
irq  input  NIRQ  wake requests, already synchronous to clk_in; not re-synced
wake_src_clr  input  1  single-cycle clear of wake_src
wakeup  output  1  one-cycle wake pulse
wake_src  output  NIRQ  sticky record of masked IRQs that caused a wake/abort
clk_enb  output  1  clock enable to gate cell
gated  output  1  high in SLEEP_DLY, GATED or WAKE_HOLD
clk_out  output  1  gated clock from ctech_clk_gate(GATE=clk_enb, CLK=clk_in)

Behaviour:
- Reset is synchronous and active-high: it acts on the posedge of clk_in while reset=1.
- Reset values: state IDLE; counter 0; sync flops 0; idle edge register 0; wakeup 0; wake_src 0; synced mode 00. Therefore clk_enb=1 and gated=0.
- Reset mid-operation, including in GATED, returns to IDLE with clk_enb=1 on the next edge.
- Definitions:
  - idle_ps = dst_idle_ss & ~dst_idle_r, where dst_idle_r is registered every cycle.
  - hit = irq & cfg_irq_mask.
- State IDLE:
  - clk_enb=1.
  - If mode==01 and idle_ps: cnt<=0, then go to GATED if cfg_sleep_dly==0, else go to SLEEP_DLY.
- State SLEEP_DLY:
  - clk_enb=1.
  - Priority 1: if |hit, go to IDLE, wakeup<=1, capture hit into wake_src (abort).
  - Priority 2: else if dst_idle_ss==0, go to IDLE with no pulse and no capture.
  - Priority 3: else if cnt==cfg_sleep_dly-1, go to GATED.
  - Otherwise cnt++.
  - Net effect: SLEEP_DLY lasts exactly cfg_sleep_dly cycles.
- State GATED:
  - clk_enb=0.
  - If |hit: go to WAKE_HOLD, cnt<=0, wakeup<=1, capture hit.
  - With mask==0, stays gated until mode change or reset.
- State WAKE_HOLD:
  - clk_enb=0; wakeup<=0.
  - If cnt==cfg_wake_cnt, go to IDLE; else cnt++.
  - Net effect: hold lasts cfg_wake_cnt+1 cycles.
- Re-entry: requires a fresh rising edge of dst_idle. A dst_idle still high after wake does not regate.
- Capture: wake_src <= (wake_src_clr ? 0 : wake_src) | captured. A capture in the same cycle as wake_src_clr wins, i.e. the new bits are set.
- Mode handling, in any state:
  - Synced mode != 01 forces state IDLE and cnt 0 on the next edge, with no wakeup pulse.
  - clk_enb = 1 for modes 00/11; 0 for mode 10; state-derived for mode 01.
- clk_enb is combinational from synced mode and state.
- Latency, with sleep_dly=0: dst_idle sampled high at edge E0, so state is GATED at E2 and clk_enb falls after E2.
- Wake latency: hit sampled at edge Ek, so wakeup is high for cycle Ek..Ek+1, and clk_enb rises after edge Ek+cfg_wake_cnt+1.

Test Plan:
1. Reset, mode 00, toggle dst_idle → clk_enb stays 1, wakeup never asserts, clk_out follows clk_in.
2. Mode 01, mask 4'b0100, sleep_dly 0, wake_cnt 3. Raise dst_idle at E0 → clk_enb=0 from E2. Pulse irq[2] → one wakeup pulse, wake_src=4'b0100, clk_enb back to 1 exactly 4 cycles after the pulse edge. irq[0] alone → no wake.
3. Mode 01, sleep_dly 5, irq[1] (masked in) asserted 3 cycles into SLEEP_DLY → abort to IDLE, wakeup pulse, wake_src=4'b0010, clk_enb never drops. Repeat with dst_idle falling instead → IDLE, no pulse, wake_src unchanged.
4. In GATED, irq=4'b1010 with mask 4'b1111 while wake_src_clr=1 and wake_src=4'b0001 → wake_src=4'b1010. Next wake on irq[0] without clear → 4'b1011.
5. In GATED, switch mode to 10 → state IDLE, clk_enb stays 0 with no wakeup. Then switch to 00 → clk_enb=1 two cycles after the change.
6. Assert reset (high) for one cycle while in WAKE_HOLD with cnt=2 → next edge: state IDLE, clk_enb=1, wakeup=0, wake_src=0. Also confirm reset has no effect between clock edges.

Source files
------------

// File: rtl/ycr_clk_gate_mc.sv
// ycr_clk_gate_mc: multi-channel core clock-gate controller.
// Gates clk_in on core idle, ungates on a masked IRQ after a hold-off.
module ctech_clk_gate (
    input  logic GATE,
    input  logic CLK,
    output logic GCLK
);
    logic r_en;

    // Enable is captured while CLK is low so GCLK never glitches.
    always_latch begin
        if (!CLK) r_en <= GATE;
    end

    assign GCLK = CLK & r_en;
endmodule

module ycr_clk_gate_mc #(
    parameter int NIRQ  = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic [1:0]       cfg_mode,
    input  logic [NIRQ-1:0]  cfg_irq_mask,
    input  logic [CNT_W-1:0] cfg_sleep_dly,
    input  logic [CNT_W-1:0] cfg_wake_cnt,
    input  logic             dst_idle,
    input  logic [NIRQ-1:0]  irq,
    input  logic             wake_src_clr,
    output logic             wakeup,
    output logic [NIRQ-1:0]  wake_src,
    output logic             clk_enb,
    output logic             gated,
    output logic             clk_out
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_SLEEP_DLY,
        S_GATED,
        S_WAKE_HOLD
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [1:0]       r_mode_s1;
    logic [1:0]       r_mode_ss;
    logic             r_idle_s1;
    logic             r_idle_ss;
    logic             r_idle_r;
    logic             r_wakeup;
    logic             w_wakeup_nxt;
    logic [NIRQ-1:0]  r_wake_src;
    logic [NIRQ-1:0]  w_cap;
    logic [NIRQ-1:0]  w_hit;
    logic             w_idle_ps;
    logic             w_mode_irq;
    logic [CNT_W-1:0] w_dly_m1;

    assign w_hit      = irq & cfg_irq_mask;
    assign w_idle_ps  = r_idle_ss & ~r_idle_r;
    assign w_mode_irq = (r_mode_ss == 2'b01);
    assign w_dly_m1   = cfg_sleep_dly - CNT_W'(1);

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_mode_s1  <= 2'b00;
            r_mode_ss  <= 2'b00;
            r_idle_s1  <= 1'b0;
            r_idle_ss  <= 1'b0;
            r_idle_r   <= 1'b0;
            r_wakeup   <= 1'b0;
            r_wake_src <= '0;
        end else begin
            r_mode_s1  <= cfg_mode;
            r_mode_ss  <= r_mode_s1;
            r_idle_s1  <= dst_idle;
            r_idle_ss  <= r_idle_s1;
            r_idle_r   <= r_idle_ss;
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_wakeup   <= w_wakeup_nxt;
            // New capture bits win over a same-cycle clear.
            r_wake_src <= (wake_src_clr ? '0 : r_wake_src) | w_cap;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_wakeup_nxt = 1'b0;
        w_cap        = '0;
        if (!w_mode_irq) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_idle_ps) begin
                        w_cnt_nxt = '0;
                        if (cfg_sleep_dly == '0)
                            w_state_nxt = S_GATED;
                        else
                            w_state_nxt = S_SLEEP_DLY;
                    end
                end
                S_SLEEP_DLY: begin
                    if (|w_hit) begin
                        w_state_nxt  = S_IDLE;
                        w_wakeup_nxt = 1'b1;
                        w_cap        = w_hit;
                    end else if (!r_idle_ss) begin
                        w_state_nxt = S_IDLE;
                    end else if (r_cnt == w_dly_m1) begin
                        w_state_nxt = S_GATED;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                S_GATED: begin
                    if (|w_hit) begin
                        w_state_nxt  = S_WAKE_HOLD;
                        w_cnt_nxt    = '0;
                        w_wakeup_nxt = 1'b1;
                        w_cap        = w_hit;
                    end
                end
                S_WAKE_HOLD: begin
                    if (r_cnt == cfg_wake_cnt)
                        w_state_nxt = S_IDLE;
                    else
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_comb begin
        unique case (r_mode_ss)
            2'b10:   clk_enb = 1'b0;
            2'b01:   clk_enb = (r_state == S_IDLE) ||
                               (r_state == S_SLEEP_DLY);
            default: clk_enb = 1'b1;
        endcase
    end

    assign gated    = (r_state != S_IDLE);
    assign wakeup   = r_wakeup;
    assign wake_src = r_wake_src;

    ctech_clk_gate u_cg (
        .GATE (clk_enb),
        .CLK  (clk_in),
        .GCLK (clk_out)
    );
endmodule

// File: tb/tb_ycr_clk_gate_mc.sv
// tb_ycr_clk_gate_mc: directed plus random stimulus against a
// phase/countdown reference model of the clock-gate controller.
module tb_ycr_clk_gate_mc;
    localparam int NIRQ  = 4;
    localparam int CNT_W = 4;

    logic             clk_in = 1'b0;
    logic             reset;
    logic [1:0]       cfg_mode;
    logic [NIRQ-1:0]  cfg_irq_mask;
    logic [CNT_W-1:0] cfg_sleep_dly;
    logic [CNT_W-1:0] cfg_wake_cnt;
    logic             dst_idle;
    logic [NIRQ-1:0]  irq;
    logic             wake_src_clr;
    logic             wakeup;
    logic [NIRQ-1:0]  wake_src;
    logic             clk_enb;
    logic             gated;
    logic             clk_out;

    int checks = 0;
    int errors = 0;

    ycr_clk_gate_mc #(.NIRQ(NIRQ), .CNT_W(CNT_W)) dut (
        .clk_in        (clk_in),
        .reset         (reset),
        .cfg_mode      (cfg_mode),
        .cfg_irq_mask  (cfg_irq_mask),
        .cfg_sleep_dly (cfg_sleep_dly),
        .cfg_wake_cnt  (cfg_wake_cnt),
        .dst_idle      (dst_idle),
        .irq           (irq),
        .wake_src_clr  (wake_src_clr),
        .wakeup        (wakeup),
        .wake_src      (wake_src),
        .clk_enb       (clk_enb),
        .gated         (gated),
        .clk_out       (clk_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 awake, 1 sleep delay, 2 asleep,
    // 3 wake hold; 'left' counts remaining cycles of the phase.
    int              ph = 0;
    int              left = 0;
    logic [1:0]      mp [2];
    logic            ip [3];
    logic            e_wk = 1'b0;
    logic [NIRQ-1:0] e_src = '0;
    logic            e_enb = 1'b1;
    logic            e_gated = 1'b0;
    logic            mvalid = 1'b0;
    logic            pvalid;
    logic            pen;
    logic [NIRQ-1:0] hit;
    logic [NIRQ-1:0] cap;

    always @(posedge clk_in) begin
        pvalid = mvalid;
        pen = e_enb;
        if (reset) begin
            ph = 0; left = 0;
            mp[0] = 2'b00; mp[1] = 2'b00;
            ip[0] = 0; ip[1] = 0; ip[2] = 0;
            e_wk = 0; e_src = '0; mvalid = 1;
        end else begin
            hit = irq & cfg_irq_mask;
            cap = '0;
            e_wk = 0;
            if (mp[1] != 2'b01) begin
                ph = 0;
            end else begin
                case (ph)
                    0: if (ip[1] && !ip[2]) begin
                        if (cfg_sleep_dly == 0) ph = 2;
                        else begin ph = 1; left = int'(cfg_sleep_dly); end
                    end
                    1: if (hit != 0) begin
                        ph = 0; e_wk = 1; cap = hit;
                    end else if (!ip[1]) begin
                        ph = 0;
                    end else begin
                        left--;
                        if (left == 0) ph = 2;
                    end
                    2: if (hit != 0) begin
                        ph = 3; left = int'(cfg_wake_cnt) + 1;
                        e_wk = 1; cap = hit;
                    end
                    default: begin
                        left--;
                        if (left == 0) ph = 0;
                    end
                endcase
            end
            e_src = (wake_src_clr ? '0 : e_src) | cap;
            mp[1] = mp[0]; mp[0] = cfg_mode;
            ip[2] = ip[1]; ip[1] = ip[0]; ip[0] = dst_idle;
        end
        e_enb = (mp[1] == 2'b10) ? 1'b0 :
                (mp[1] == 2'b01) ? (ph < 2) : 1'b1;
        e_gated = (ph != 0);
        #1;
        if (mvalid) begin
            chk("clk_enb", clk_enb, e_enb);
            chk("gated", gated, e_gated);
            chk("wakeup", wakeup, e_wk);
            chk("wake_src", wake_src, e_src);
        end
        if (pvalid) chk("clk_out", clk_out, pen);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic go_gated();
        dst_idle = 1'b0;
        tick(3);
        dst_idle = 1'b1;
        tick(3);
        chk("go_gated_enb", clk_enb, 0);
    endtask

    initial begin
        reset = 1; cfg_mode = 0; cfg_irq_mask = 0;
        cfg_sleep_dly = 0; cfg_wake_cnt = 0;
        dst_idle = 0; irq = 0; wake_src_clr = 0;
        tick(3);
        chk("rst_enb", clk_enb, 1);
        chk("rst_gated", gated, 0);
        chk("rst_src", wake_src, 0);
        reset = 0;
        // mode 00: idle toggles never gate
        for (int i = 0; i < 6; i++) begin
            dst_idle = ~dst_idle;
            tick(3);
        end
        chk("m0_enb", clk_enb, 1);
        dst_idle = 0;
        // mode 01, immediate gating and IRQ wake
        cfg_mode = 2'b01; cfg_irq_mask = 4'b0100;
        cfg_sleep_dly = 0; cfg_wake_cnt = 3;
        tick(4);
        dst_idle = 1;
        tick(2);
        chk("lat_e1_enb", clk_enb, 1);
        tick(1);
        chk("lat_e2_enb", clk_enb, 0);
        irq = 4'b0001;
        tick(3);
        chk("unmask_enb", clk_enb, 0);
        chk("unmask_wk", wakeup, 0);
        irq = 4'b0100;
        tick(1);
        irq = 0;
        chk("wake_pulse", wakeup, 1);
        chk("wake_src1", wake_src, 4'b0100);
        tick(3);
        chk("hold_enb", clk_enb, 0);
        tick(1);
        chk("hold_end", clk_enb, 1);
        tick(5);
        chk("noregate", gated, 0);
        dst_idle = 0;
        wake_src_clr = 1;
        tick(1);
        wake_src_clr = 0;
        tick(3);
        // sleep delay abort by IRQ, then by idle drop
        cfg_irq_mask = 4'b0010; cfg_sleep_dly = 5;
        dst_idle = 1;
        tick(5);
        irq = 4'b0010;
        tick(1);
        irq = 0;
        chk("abort_wk", wakeup, 1);
        chk("abort_src", wake_src, 4'b0010);
        chk("abort_enb", clk_enb, 1);
        dst_idle = 0;
        tick(4);
        dst_idle = 1;
        tick(4);
        dst_idle = 0;
        tick(6);
        chk("drop_src", wake_src, 4'b0010);
        chk("drop_gated", gated, 0);
        // capture vs clear
        cfg_irq_mask = 4'b1111; cfg_sleep_dly = 0;
        wake_src_clr = 1;
        tick(1);
        wake_src_clr = 0;
        go_gated();
        irq = 4'b0001;
        tick(1);
        irq = 0;
        chk("src_0001", wake_src, 4'b0001);
        tick(5);
        go_gated();
        irq = 4'b1010; wake_src_clr = 1;
        tick(1);
        irq = 0; wake_src_clr = 0;
        chk("src_1010", wake_src, 4'b1010);
        tick(5);
        go_gated();
        irq = 4'b0001;
        tick(1);
        irq = 0;
        chk("src_1011", wake_src, 4'b1011);
        tick(5);
        // force-gate mode from GATED, then release
        go_gated();
        cfg_mode = 2'b10;
        tick(3);
        chk("m2_enb", clk_enb, 0);
        chk("m2_gated", gated, 0);
        cfg_mode = 2'b00;
        tick(1);
        chk("m0_e0", clk_enb, 0);
        tick(1);
        chk("m0_e1", clk_enb, 1);
        // reset inside WAKE_HOLD, plus a between-edge pulse
        cfg_mode = 2'b01;
        tick(3);
        go_gated();
        irq = 4'b0100;
        tick(1);
        irq = 0;
        tick(1);
        #2 reset = 1;
        #2;
        chk("glitch_enb", clk_enb, 0);
        chk("glitch_gated", gated, 1);
        chk("glitch_src", wake_src, 4'b1111);
        reset = 0;
        tick(1);
        reset = 1;
        tick(1);
        reset = 0;
        chk("whrst_enb", clk_enb, 1);
        chk("whrst_gated", gated, 0);
        chk("whrst_wk", wakeup, 0);
        chk("whrst_src", wake_src, 0);
        // random phase
        cfg_mode = 2'b01;
        cfg_wake_cnt = 2; cfg_sleep_dly = 1;
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                reset = 1;
                cfg_sleep_dly = CNT_W'($urandom_range(0, 7));
                cfg_wake_cnt = CNT_W'($urandom_range(0, 6));
                cfg_irq_mask = NIRQ'($urandom);
            end else begin
                reset = 0;
            end
            if ($urandom_range(0, 63) == 0) begin
                case ($urandom_range(0, 9))
                    7: cfg_mode = 2'b00;
                    8: cfg_mode = 2'b10;
                    9: cfg_mode = 2'b11;
                    default: cfg_mode = 2'b01;
                endcase
            end
            if ($urandom_range(0, 15) == 0) dst_idle = ~dst_idle;
            irq = ($urandom_range(0, 11) == 0) ? NIRQ'($urandom) : '0;
            wake_src_clr = ($urandom_range(0, 15) == 0);
            tick(1);
        end
        reset = 0;
        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
